// File: rtl/obstacle_row_gen_pkg.sv
// car_dash_pkg: shared constants, FSM state encoding and helpers for obstacle_row_gen.
// Rev 1.0 - initial release.
`default_nettype none

package car_dash_pkg;

  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam int          MAX_ROW_W = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    PLACE = 2'd2,
    OUT   = 2'd3
  } state_t;

  // Never returns 0 so that counters sized with it stay legal for degenerate parameters.
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic logic [MAX_ROW_W-1:0] wall_mask(input int num_roads, input int road_w);
    logic [MAX_ROW_W-1:0] m;
    m = '0;
    for (int r = 0; r < num_roads; r++) begin
      m[r*road_w]            = 1'b1;
      m[r*road_w + road_w-1] = 1'b1;
    end
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/obstacle_row_gen_if.sv
// obstacle_row_gen_if: request / row-delivery handshake bundle for obstacle_row_gen.
// Rev 1.0 - initial release.
`default_nettype none

interface obstacle_row_gen_if #(
  parameter int ROW_W = 16
) ();
  logic             gen_req;
  logic             seq_ready;
  logic             seq_valid;
  logic [ROW_W-1:0] seq_out;
  logic             busy;

  modport master (output gen_req, output seq_ready,
                  input  seq_valid, input seq_out, input busy);
  modport slave  (input  gen_req, input seq_ready,
                  output seq_valid, output seq_out, output busy);
endinterface

`default_nettype wire

// File: rtl/obstacle_row_gen_lfsr.sv
// dash_lfsr: free-running 16-bit Galois LFSR (x^16+x^14+x^13+x^11), reset to SEED.
// Rev 1.0 - initial release.
`default_nettype none

module dash_lfsr
  import car_dash_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  wire logic        clk,
  input  wire logic        rst,
  output logic      [15:0] o_q
);

  logic [15:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_q <= SEED;
    else     r_q <= {1'b0, r_q[15:1]} ^ (r_q[0] ? LFSR_POLY : 16'h0000);
  end

  assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/obstacle_row_gen.sv
// obstacle_row_gen: builds walled obstacle rows from an LFSR and hands them out over valid/ready.
// Optional feature macro: SAFE_LANE_EN (keeps a drifting drivable lane per road). Rev 1.0.
`default_nettype none

module obstacle_row_gen
  import car_dash_pkg::*;
#(
  parameter int          NUM_ROADS     = 2,
  parameter int          ROAD_W        = 8,
  parameter int          OBST_PER_ROAD = 3,
  parameter int          MAX_TRIES     = 8,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input wire logic          clk,
  input wire logic          rst,
  obstacle_row_gen_if.slave bus
);

  localparam int IDX_W = idx_w(ROAD_W);
  localparam int ROW_W = NUM_ROADS * ROAD_W;
  localparam int R_W   = idx_w(NUM_ROADS);
  localparam int O_W   = idx_w(OBST_PER_ROAD);
  localparam int T_W   = idx_w(MAX_TRIES);
  localparam logic [ROW_W-1:0] WALL_MASK = ROW_W'(wall_mask(NUM_ROADS, ROAD_W));

  state_t           r_state;
  logic [ROW_W-1:0] r_work;
  logic [ROW_W-1:0] r_out;
  logic             r_valid;
  logic             r_busy;
  logic [R_W-1:0]   r_road;
  logic [O_W-1:0]   r_obst;
  logic [T_W-1:0]   r_tries;

  logic [15:0]      w_lfsr;
  logic [IDX_W-1:0] w_cand;
  logic [31:0]      w_pos;
  logic [ROW_W-1:0] w_set;
  logic [ROW_W-1:0] w_work_nxt;
  logic             w_in_range;
  logic             w_lane_clr;
  logic             w_safe_ok;
  logic             w_accept;
  logic             w_unused_lfsr;

  dash_lfsr #(.SEED(SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .o_q (w_lfsr)
  );

  assign w_cand        = w_lfsr[IDX_W-1:0];
  assign w_unused_lfsr = ^w_lfsr[15:IDX_W];

`ifdef SAFE_LANE_EN
  logic [NUM_ROADS-1:0][IDX_W-1:0] r_safe;

  // The safe lane drifts by at most one lane per row so a drivable path always exists.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_ROADS; r++) r_safe[r] <= IDX_W'(ROAD_W/2);
    end else if (r_state == CLEAR) begin
      for (int r = 0; r < NUM_ROADS; r++) begin
        if (w_lfsr[1:0] == 2'b01 && r_safe[r] > IDX_W'(1))
          r_safe[r] <= r_safe[r] - 1'b1;
        else if (w_lfsr[1:0] == 2'b10 && r_safe[r] < IDX_W'(ROAD_W-2))
          r_safe[r] <= r_safe[r] + 1'b1;
      end
    end
  end

  assign w_safe_ok = (w_cand != r_safe[r_road]);
`else
  assign w_safe_ok = 1'b1;
`endif

  always_comb begin
    w_pos      = 32'(r_road) * 32'(ROAD_W) + 32'(w_cand);
    w_set      = ROW_W'(1) << w_pos;
    w_in_range = (w_cand != '0) && (w_cand <= IDX_W'(ROAD_W-2));
    w_lane_clr = ((r_work & w_set) == '0);
    w_accept   = w_in_range && w_lane_clr && w_safe_ok;
    w_work_nxt = w_accept ? (r_work | w_set) : r_work;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_work  <= WALL_MASK;
      r_out   <= WALL_MASK;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_road  <= '0;
      r_obst  <= '0;
      r_tries <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.gen_req) begin
            r_busy  <= 1'b1;
            r_state <= CLEAR;
          end
        end
        CLEAR: begin
          r_work  <= WALL_MASK;
          r_road  <= '0;
          r_obst  <= '0;
          r_tries <= '0;
          r_state <= PLACE;
        end
        PLACE: begin
          r_work <= w_work_nxt;
          if (w_accept || r_tries == T_W'(MAX_TRIES-1)) begin
            r_tries <= '0;
            if (r_obst == O_W'(OBST_PER_ROAD-1)) begin
              r_obst <= '0;
              if (r_road == R_W'(NUM_ROADS-1)) begin
                r_out   <= w_work_nxt;
                r_valid <= 1'b1;
                r_state <= OUT;
              end else begin
                r_road <= r_road + 1'b1;
              end
            end else begin
              r_obst <= r_obst + 1'b1;
            end
          end else begin
            r_tries <= r_tries + 1'b1;
          end
        end
        OUT: begin
          if (bus.seq_ready) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.seq_valid = r_valid;
  assign bus.seq_out   = r_out;
  assign bus.busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_obstacle_row_gen.sv
// tb_obstacle_row_gen: scoreboard bench for obstacle_row_gen (default and MAX_TRIES=1 instances).
// Rev 1.0 - initial release.
`default_nettype none

module tb_obstacle_row_gen;
  import car_dash_pkg::*;

  typedef struct {
    logic [15:0] row;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_err    = 0;

  logic [15:0]     m_lfsr;
  logic [1:0][2:0] m_safe [2];
  exp_t            sb0 [$];
  exp_t            sb1 [$];

  obstacle_row_gen_if #(.ROW_W(16)) b0 ();
  obstacle_row_gen_if #(.ROW_W(16)) b1 ();

  obstacle_row_gen u_dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
  obstacle_row_gen #(.MAX_TRIES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

  always #5 clk = ~clk;

  function automatic logic [15:0] lstep(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= lstep(m_lfsr);
  end

  // l0 is the LFSR value sampled at the edge that accepts gen_req.
  function automatic void model_row(input logic [15:0] l0, input int max_tries,
                                    input logic [1:0][2:0] sf_in, output logic [15:0] row,
                                    output int lat, output logic [1:0][2:0] sf_out);
    logic [15:0] l;
    int          c;
    bit          done;
    bit          safe_ok;
    l      = lstep(l0);
    sf_out = sf_in;
`ifdef SAFE_LANE_EN
    for (int r = 0; r < 2; r++) begin
      if (l[1:0] == 2'b01 && sf_out[r] > 3'd1)      sf_out[r] = sf_out[r] - 3'd1;
      else if (l[1:0] == 2'b10 && sf_out[r] < 3'd6) sf_out[r] = sf_out[r] + 3'd1;
    end
`endif
    l   = lstep(l);
    row = 16'h8181;
    lat = 2;
    for (int r = 0; r < 2; r++) begin
      for (int o = 0; o < 3; o++) begin
        done = 1'b0;
        for (int t = 0; t < max_tries && !done; t++) begin
          c = int'(l[2:0]);
          l = lstep(l);
          lat++;
          safe_ok = 1'b1;
`ifdef SAFE_LANE_EN
          safe_ok = (c != int'(sf_out[r]));
`endif
          if (c >= 1 && c <= 6 && !row[r*8+c] && safe_ok) begin
            row[r*8+c] = 1'b1;
            done       = 1'b1;
          end
        end
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int sel, input logic v);
    if (sel == 0) b0.gen_req = v; else b1.gen_req = v;
  endtask

  task automatic set_rdy(input int sel, input logic v);
    if (sel == 0) b0.seq_ready = v; else b1.seq_ready = v;
  endtask

  function automatic logic  get_valid(input int sel); return sel == 0 ? b0.seq_valid : b1.seq_valid; endfunction
  function automatic logic  get_busy (input int sel); return sel == 0 ? b0.busy      : b1.busy;      endfunction
  function automatic logic [15:0] get_out(input int sel); return sel == 0 ? b0.seq_out : b1.seq_out; endfunction

  task automatic run_row(input int sel, input int hold, output logic [15:0] got);
    exp_t e;
    exp_t p;
    int   n;
    @(negedge clk);
    model_row(m_lfsr, (sel == 0) ? 8 : 1, m_safe[sel], e.row, e.lat, m_safe[sel]);
    if (sel == 0) sb0.push_back(e); else sb1.push_back(e);
    set_req(sel, 1'b1);
    set_rdy(sel, hold == 0);
    @(negedge clk);
    set_req(sel, 1'b0);
    n = 1;
    while (!get_valid(sel) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("valid_seen", 32'(get_valid(sel)), 32'd1);
    p = (sel == 0) ? sb0.pop_front() : sb1.pop_front();
    got = get_out(sel);
    check("row", 32'(got), 32'(p.row));
    check("latency", n, p.lat);
    check("busy_in_out", 32'(get_busy(sel)), 32'd1);
`ifdef SAFE_LANE_EN
    for (int r = 0; r < 2; r++) check("safe_lane_clear", 32'(got[r*8 + int'(m_safe[sel][r])]), 32'd0);
`endif
    for (int i = 0; i < hold; i++) begin
      set_req(sel, (i % 5) == 0);
      @(negedge clk);
      check("hold_row", 32'(get_out(sel)), 32'(got));
      check("hold_valid", 32'(get_valid(sel)), 32'd1);
      check("hold_busy", 32'(get_busy(sel)), 32'd1);
    end
    set_rdy(sel, 1'b1);
    set_req(sel, 1'b1);
    @(negedge clk);
    set_req(sel, 1'b0);
    set_rdy(sel, 1'b0);
    check("hs_valid", 32'(get_valid(sel)), 32'd0);
    check("hs_busy", 32'(get_busy(sel)), 32'd0);
    check("hs_row_held", 32'(get_out(sel)), 32'(got));
    repeat (3) @(negedge clk);
    check("dropped_req_busy", 32'(get_busy(sel)), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_safe[0] = {3'd4, 3'd4};
    m_safe[1] = {3'd4, 3'd4};
    #1;
    check("rst_out", 32'(b0.seq_out), 32'h8181);
    check("rst_busy", 32'(b0.busy), 32'd0);
    check("rst_valid", 32'(b0.seq_valid), 32'd0);
    sb0.delete();
    sb1.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] got;
    logic [15:0] row_a;
    logic [15:0] row_b;
    b0.gen_req = 1'b0; b0.seq_ready = 1'b0;
    b1.gen_req = 1'b0; b1.seq_ready = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    repeat (100) @(negedge clk);
    check("idle_out", 32'(b0.seq_out), 32'h8181);
    check("idle_valid", 32'(b0.seq_valid), 32'd0);
    check("idle_busy", 32'(b0.busy), 32'd0);
    check("idle_out1", 32'(b1.seq_out), 32'h8181);

    run_row(0, 0, got);
    check("walls", 32'(got & 16'h8181), 32'h8181);
    check("pop_lo_ok", 32'($countones(got[7:0]) inside {[2:5]}), 32'd1);
    check("pop_hi_ok", 32'($countones(got[15:8]) inside {[2:5]}), 32'd1);

    run_row(0, 20, got);
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(0, 7)) @(negedge clk);
      run_row(0, k % 3, got);
    end

    @(negedge clk);
    set_req(0, 1'b1);
    @(negedge clk);
    set_req(0, 1'b0);
    repeat (4) @(negedge clk);
    do_reset();
    repeat (5) @(negedge clk);
    run_row(0, 0, row_a);
    do_reset();
    repeat (5) @(negedge clk);
    run_row(0, 0, row_b);
    check("repeat_row", 32'(row_b), 32'(row_a));

    for (int k = 0; k < 150; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_row(1, 0, got);
      check("mt1_walls", 32'(got & 16'h8181), 32'h8181);
    end

`ifdef SAFE_LANE_EN
    for (int k = 0; k < 300; k++) begin
      logic [1:0][2:0] prev;
      prev = m_safe[0];
      run_row(0, 0, got);
      for (int r = 0; r < 2; r++)
        check("safe_step", 32'((int'(m_safe[0][r]) - int'(prev[r])) inside {[-1:1]}), 32'd1);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
